// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   BytesPerWord : stream bytes per instruction word
//   CntWidth     : width of the word-count header field
//   state_e      : loader FSM encoding (3 bits)
package imem_loader_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned CntWidth     = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdrLo = 3'd1,
    StHdrHi = 3'd2,
    StData  = 3'd3,
    StChk   = 3'd4,
    StDone  = 3'd5,
    StError = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian stream bytes into one 32-bit word.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart at lane 0 (new load)
//   accept      : a data byte is consumed this cycle
//   byte_data   : the byte being consumed
//   word        : assembled word, valid while word_ready is high
//   word_ready  : high when the lane-3 byte is being accepted
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;

  // Bytes enter at the top and move down, so byte 0 ends up in bits [7:0].
  assign word       = {byte_data, shift_q};
  assign word_ready = accept && (lane_q == 2'(BytesPerWord - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else if (accept) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {byte_data, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program image as a byte stream
// (CNT_LO, CNT_HI, 4*N data bytes, CHK) and writes it word by word into
// instruction memory. The core is held in reset until a verified image is loaded.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start                  : pulse that begins (IDLE) or restarts (DONE/ERROR) a load
//   byte_valid, byte_data  : stream byte from the source
//   byte_ready             : loader accepts the byte this cycle
//   imem_we/addr/wdata     : registered instruction-memory write port
//   core_reset             : high in every state except DONE
//   load_done, load_error  : image verified / count overflow or checksum mismatch
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned Width         = 32,
  parameter int unsigned Address_Width = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     imem_we,
  output logic [Address_Width-1:0] imem_addr,
  output logic [Width-1:0]         imem_wdata,
  output logic                     core_reset,
  output logic                     load_done,
  output logic                     load_error
);

  localparam int unsigned Depth = 2 ** Address_Width;

  state_e                   state_q;
  logic [CntWidth-1:0]      n_q;
  logic [CntWidth-1:0]      word_cnt_q;
  logic [7:0]               chk_q;
  logic                     we_q;
  logic [Address_Width-1:0] addr_q;
  logic [Width-1:0]         wdata_q;

  logic                accept;
  logic                asm_clear;
  logic [31:0]         asm_word;
  logic                asm_word_ready;
  logic [CntWidth-1:0] hdr_n;
  logic                last_word;

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      StHdrLo, StHdrHi, StData, StChk: byte_ready = 1'b1;
      default:                         byte_ready = 1'b0;
    endcase
  end

  assign accept    = byte_valid && byte_ready;
  assign asm_clear = start && ((state_q == StIdle) || (state_q == StDone) ||
                               (state_q == StError));
  assign hdr_n     = {byte_data, n_q[7:0]};
  assign last_word = (word_cnt_q == (n_q - CntWidth'(1)));

  imem_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .accept     (accept && (state_q == StData)),
    .byte_data  (byte_data),
    .word       (asm_word),
    .word_ready (asm_word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      word_cnt_q <= '0;
      chk_q      <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q    <= StHdrLo;
            n_q        <= '0;
            word_cnt_q <= '0;
            chk_q      <= 8'd0;
          end
        end
        StHdrLo: begin
          if (accept) begin
            n_q[7:0] <= byte_data;
            chk_q    <= chk_q ^ byte_data;
            state_q  <= StHdrHi;
          end
        end
        StHdrHi: begin
          if (accept) begin
            n_q   <= hdr_n;
            chk_q <= chk_q ^ byte_data;
            if (hdr_n > CntWidth'(Depth)) begin
              state_q <= StError;
            end else if (hdr_n == '0) begin
              state_q <= StChk;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            chk_q <= chk_q ^ byte_data;
            if (asm_word_ready) begin
              we_q       <= 1'b1;
              addr_q     <= word_cnt_q[Address_Width-1:0];
              wdata_q    <= asm_word;
              word_cnt_q <= word_cnt_q + CntWidth'(1);
              if (last_word) begin
                state_q <= StChk;
              end
            end
          end
        end
        StChk: begin
          if (accept) begin
            state_q <= (byte_data == chk_q) ? StDone : StError;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = (state_q != StDone);
  assign load_done  = (state_q == StDone);
  assign load_error = (state_q == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: a cycle-by-cycle vector table for a
// basic two-word load, followed by hand-written sequences for the error,
// empty-image, full-depth, restart and mid-load reset cases.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_fail   = 0;

  imem_loader #(
    .Width         (32),
    .Address_Width (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  logic [4:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_count = 0;

  always @(negedge clk) begin
    if (!reset && imem_we && wr_count < 64) begin
      wr_addr[wr_count] = imem_addr;
      wr_data[wr_count] = imem_wdata;
      wr_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        cr;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  logic [7:0]  stream [$];
  logic [31:0] exp_words [32];

  task automatic pulse_start();
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    #1;
    while (!byte_ready && waitc < 50) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!byte_ready) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    #1;
  endtask

  // Streams the queued bytes; optional random gaps and a start pulse before byte mid_start.
  task automatic send_stream(input bit gaps, input int mid_start);
    foreach (stream[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) idle_cycle();
      if (i == mid_start) pulse_start();
      send_byte(stream[i]);
    end
    idle_cycle();
  endtask

  // Two-word image used by several tests; XOR of all preceding bytes is 0x92.
  task automatic build_two_word(input logic [7:0] chk);
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, chk};
  endtask

  task automatic check_writes(input string name, input int n);
    check({name, "_count"}, wr_count, n);
    for (int i = 0; i < n && i < wr_count; i++) begin
      check({name, "_addr"}, {27'd0, wr_addr[i]}, i);
      check({name, "_data"}, wr_data[i], exp_words[i]);
    end
  endtask

  initial begin
    logic [7:0] x;
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    //          start valid data   ready we addr  wdata         cr    done  err
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h93, 1'b1, 1'b1, 5'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 5'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h92, 1'b1, 1'b1, 5'd1, 32'h00100093, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 32'h00100093, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: vector table, two-word load.
    wr_count = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start      = vecs[i].start;
      byte_valid = vecs[i].valid;
      byte_data  = vecs[i].data;
      #1;
      check($sformatf("t1_v%0d_ready", i), {31'd0, byte_ready}, {31'd0, vecs[i].ready});
      check($sformatf("t1_v%0d_we", i),    {31'd0, imem_we},    {31'd0, vecs[i].we});
      check($sformatf("t1_v%0d_addr", i),  {27'd0, imem_addr},  {27'd0, vecs[i].addr});
      check($sformatf("t1_v%0d_wdata", i), imem_wdata,          vecs[i].wdata);
      check($sformatf("t1_v%0d_cr", i),    {31'd0, core_reset}, {31'd0, vecs[i].cr});
      check($sformatf("t1_v%0d_done", i),  {31'd0, load_done},  {31'd0, vecs[i].done});
      check($sformatf("t1_v%0d_err", i),   {31'd0, load_error}, {31'd0, vecs[i].err});
    end
    exp_words[0] = 32'h00000013;
    exp_words[1] = 32'h00100093;
    check_writes("t1", 2);

    // Test 2: bad checksum, restarted from DONE.
    wr_count = 0;
    build_two_word(8'h00);
    pulse_start();
    send_stream(1'b0, -1);
    check("t2_error", {31'd0, load_error}, 32'd1);
    check("t2_core_reset", {31'd0, core_reset}, 32'd1);
    check("t2_done", {31'd0, load_done}, 32'd0);
    idle_cycle();
    check("t2_ready_after", {31'd0, byte_ready}, 32'd0);

    // Test 3: N = 33 overflows the memory depth.
    wr_count = 0;
    pulse_start();
    send_byte(8'h21);
    send_byte(8'h00);
    idle_cycle();
    check("t3_error_next_cycle", {31'd0, load_error}, 32'd1);
    repeat (5) idle_cycle();
    check("t3_no_writes", wr_count, 0);

    // Test 4: empty image, then restart from DONE.
    wr_count = 0;
    stream = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_stream(1'b0, -1);
    check("t4_done", {31'd0, load_done}, 32'd1);
    check("t4_core_reset", {31'd0, core_reset}, 32'd0);
    check("t4_no_writes", wr_count, 0);
    pulse_start();
    #1;
    check("t4_restart_core_reset", {31'd0, core_reset}, 32'd1);
    check("t4_restart_ready", {31'd0, byte_ready}, 32'd1);
    check("t4_restart_done", {31'd0, load_done}, 32'd0);

    // Test 5: full-depth image with gaps; loader is already in HDR_LO.
    wr_count = 0;
    stream = '{8'h20, 8'h00};
    x = 8'h20;
    for (int k = 0; k < 32; k++) begin
      exp_words[k] = 32'(k) * 32'h01020304 + 32'h13579BDF;
      for (int b = 0; b < 4; b++) begin
        stream.push_back(exp_words[k][8*b +: 8]);
        x ^= exp_words[k][8*b +: 8];
      end
    end
    stream.push_back(x);
    send_stream(1'b1, 2 + 4 * 5 + 1);
    check("t5_done", {31'd0, load_done}, 32'd1);
    check("t5_core_reset", {31'd0, core_reset}, 32'd0);
    check_writes("t5", 32);
    check("t5_last_addr", {27'd0, imem_addr}, 32'h1F);

    // Test 6: reset after six data bytes, then a fresh load.
    wr_count = 0;
    build_two_word(8'h92);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    @(negedge clk);
    reset      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    #1;
    check("t6_ready", {31'd0, byte_ready}, 32'd0);
    check("t6_we", {31'd0, imem_we}, 32'd0);
    check("t6_addr", {27'd0, imem_addr}, 32'd0);
    check("t6_wdata", imem_wdata, 32'd0);
    check("t6_core_reset", {31'd0, core_reset}, 32'd1);
    check("t6_done", {31'd0, load_done}, 32'd0);
    check("t6_err", {31'd0, load_error}, 32'd0);
    reset = 1'b0;
    wr_count = 0;
    exp_words[0] = 32'h00000013;
    exp_words[1] = 32'h00100093;
    pulse_start();
    send_stream(1'b0, -1);
    check("t6_reload_done", {31'd0, load_done}, 32'd1);
    check_writes("t6", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case a sequence stalls.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
